// File: rtl/mem_pipeline_reg_if.sv
// Execute-to-Memory boundary bundle: E-stage fields in, registered M-stage fields out,
// plus the stall/bubble controls from the pipeline control unit.
interface mem_pipeline_reg_if #(
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              M_stall;
  logic              M_bubble;
  logic [OP_W-1:0]   E_op;
  logic [DATA_W-1:0] e_valE;
  logic [DATA_W-1:0] E_valA;
  logic [REG_W-1:0]  E_dstE;
  logic [REG_W-1:0]  E_dstM;
  logic [OP_W-1:0]   M_op;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [REG_W-1:0]  M_dstE;
  logic [REG_W-1:0]  M_dstM;
  logic              M_valid;

  // Execute stage and control unit side.
  modport master (
    output M_stall, M_bubble, E_op, e_valE, E_valA, E_dstE, E_dstM,
    input  M_op, M_valE, M_valA, M_dstE, M_dstM, M_valid
  );

  // The pipeline register itself.
  modport slave (
    input  M_stall, M_bubble, E_op, e_valE, E_valA, E_dstE, E_dstM,
    output M_op, M_valE, M_valA, M_dstE, M_dstM, M_valid
  );
endinterface

// File: rtl/mem_pipeline_reg.sv
// E/M pipeline register: one-cycle capture of the Execute-stage results with
// bubble (NOP insert, highest priority) and stall (hold) control.
module mem_pipeline_reg #(
  parameter int              OP_W   = 6,
  parameter int              DATA_W = 32,
  parameter int              REG_W  = 5,
  parameter logic [OP_W-1:0] NOP_OP = '0
) (
  input logic              clk,
  input logic              rst_n,
  mem_pipeline_reg_if.slave bus
);

  logic [OP_W-1:0]   op_p0;
  logic [DATA_W-1:0] val_e_p0;
  logic [DATA_W-1:0] val_a_p0;
  logic [REG_W-1:0]  dst_e_p0;
  logic [REG_W-1:0]  dst_m_p0;
  logic              vld_p0;

  // E -> M boundary. A bubble must clear the destinations too, so that a
  // squashed instruction can never appear as a forwarding source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0    <= NOP_OP;
      val_e_p0 <= '0;
      val_a_p0 <= '0;
      dst_e_p0 <= '0;
      dst_m_p0 <= '0;
      vld_p0   <= 1'b0;
    end else if (bus.M_bubble) begin
      op_p0    <= NOP_OP;
      val_e_p0 <= '0;
      val_a_p0 <= '0;
      dst_e_p0 <= '0;
      dst_m_p0 <= '0;
      vld_p0   <= 1'b0;
    end else if (!bus.M_stall) begin
      op_p0    <= bus.E_op;
      val_e_p0 <= bus.e_valE;
      val_a_p0 <= bus.E_valA;
      dst_e_p0 <= bus.E_dstE;
      dst_m_p0 <= bus.E_dstM;
      vld_p0   <= 1'b1;
    end
  end

  assign bus.M_op    = op_p0;
  assign bus.M_valE  = val_e_p0;
  assign bus.M_valA  = val_a_p0;
  assign bus.M_dstE  = dst_e_p0;
  assign bus.M_dstM  = dst_m_p0;
  assign bus.M_valid = vld_p0;

endmodule

// File: tb/tb_mem_pipeline_reg.sv
// Directed bench for the E/M pipeline register: reset, capture, stall, bubble,
// asynchronous mid-stream reset and full-width values.
module tb_mem_pipeline_reg;
  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_pipeline_reg_if #(.OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  mem_pipeline_reg #(
    .OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W), .NOP_OP(6'b000000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] op, input logic [31:0] ve,
                           input logic [31:0] va, input logic [4:0] de, input logic [4:0] dm,
                           input logic v);
    check({tag, ".op"},    64'(bus.M_op),    64'(op));
    check({tag, ".valE"},  64'(bus.M_valE),  64'(ve));
    check({tag, ".valA"},  64'(bus.M_valA),  64'(va));
    check({tag, ".dstE"},  64'(bus.M_dstE),  64'(de));
    check({tag, ".dstM"},  64'(bus.M_dstM),  64'(dm));
    check({tag, ".valid"}, 64'(bus.M_valid), 64'(v));
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] ve, input logic [31:0] va,
                       input logic [4:0] de, input logic [4:0] dm);
    bus.E_op   = op;
    bus.e_valE = ve;
    bus.E_valA = va;
    bus.E_dstE = de;
    bus.E_dstM = dm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] seq_op [7];

  initial begin
    checks = 0;
    errors = 0;
    seq_op = '{6'b000000, 6'b001100, 6'b001000, 6'b000010, 6'b100011, 6'b101011, 6'b001101};

    // Reset held across clock edges with all-ones inputs
    rst_n        = 1'b0;
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;
    drive(6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd31);
    step;
    check_all("rst_edge1", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step;
    check_all("rst_edge2", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("rst_release", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step;
    check_all("first_cap", 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd31, 1'b1);

    // Sequential capture; mid-cycle input changes must not leak through
    for (int i = 0; i < 7; i++) begin
      drive(seq_op[i], 32'(i + 1), 32'(i + 1), 5'(i + 1), 5'(i + 1));
      step;
      check_all($sformatf("seq%0d", i + 1), seq_op[i], 32'(i + 1), 32'(i + 1),
                5'(i + 1), 5'(i + 1), 1'b1);
      drive(6'h15, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd17, 5'd19);
      #2;
      check_all($sformatf("seq%0d_mid", i + 1), seq_op[i], 32'(i + 1), 32'(i + 1),
                5'(i + 1), 5'(i + 1), 1'b1);
    end

    // Stall holds for two edges, then new data loads
    drive(6'b100011, 32'h100, 32'h55, 5'd0, 5'd8);
    step;
    check_all("stall_pre", 6'b100011, 32'h100, 32'h55, 5'd0, 5'd8, 1'b1);
    bus.M_stall = 1'b1;
    drive(6'b101011, 32'd6, 32'd6, 5'd6, 5'd6);
    step;
    check_all("stall1", 6'b100011, 32'h100, 32'h55, 5'd0, 5'd8, 1'b1);
    step;
    check_all("stall2", 6'b100011, 32'h100, 32'h55, 5'd0, 5'd8, 1'b1);
    bus.M_stall = 1'b0;
    step;
    check_all("stall_rel", 6'b101011, 32'd6, 32'd6, 5'd6, 5'd6, 1'b1);

    // Bubble overrides stall; a stalled bubble stays a bubble
    bus.M_stall  = 1'b1;
    bus.M_bubble = 1'b1;
    drive(6'b001000, 32'd9, 32'd9, 5'd9, 5'd9);
    step;
    check_all("bubble", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    bus.M_bubble = 1'b0;
    step;
    check_all("bubble_stall", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    bus.M_stall = 1'b0;
    step;
    check_all("bubble_rel", 6'b001000, 32'd9, 32'd9, 5'd9, 5'd9, 1'b1);

    // Asynchronous reset between edges
    drive(6'b001101, 32'd7, 32'd7, 5'd7, 5'd7);
    step;
    check_all("async_pre", 6'b001101, 32'd7, 32'd7, 5'd7, 5'd7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check_all("async_rel", 6'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step;
    check_all("async_cap", 6'b001101, 32'd7, 32'd7, 5'd7, 5'd7, 1'b1);

    // Full-width values, no truncation or sign effects
    drive(6'b111111, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 5'd31);
    step;
    check_all("full", 6'b111111, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 5'd31, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_pipeline_reg.md
Name: mem_pipeline_reg

Overview:
- Execute-to-Memory (E/M) pipeline register of the 5-stage pipelined MIPS CPU.
- Captures the E-stage opcode, ALU result (e_valE), forwarded operand (E_valA) and destination register indices (E_dstE, E_dstM) on each rising clock edge.
- Presents them to the Memory stage and the forwarding/hazard logic as M_*.
- Supports stall (hold) and bubble (insert NOP) control from the pipeline control unit.

Parameters:
- OP_W, 6, opcode width.
- DATA_W, 32, data path width for valE/valA.
- REG_W, 5, register index width.
- NOP_OP, 6'b000000, opcode loaded on reset/bubble; with dst=0 it is architecturally inert.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- M_stall  input  1  hold current contents.
- M_bubble  input  1  load NOP bubble.
- E_op  input  OP_W  opcode from Execute stage.
- e_valE  input  DATA_W  ALU result from Execute stage.
- E_valA  input  DATA_W  operand A (store data) from Execute stage.
- E_dstE  input  REG_W  ALU-result destination register.
- E_dstM  input  REG_W  memory-load destination register.
- M_op  output  OP_W  registered opcode.
- M_valE  output  DATA_W  registered ALU result.
- M_valA  output  DATA_W  registered operand A.
- M_dstE  output  REG_W  registered ALU destination.
- M_dstM  output  REG_W  registered load destination.
- M_valid  output  1  1 = holds a real instruction; 0 = reset/bubble.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Clock port is clk; reset port is rst_n.
  - All outputs are driven directly from flops; no combinational input-to-output path.
- Reset: rst_n low forces, immediately and independent of clk:
  - M_op=NOP_OP, M_valE=0, M_valA=0, M_dstE=0, M_dstM=0, M_valid=0.
  - Outputs hold these values while rst_n is low.
  - First capture happens on the first rising clk edge after rst_n deasserts.
  - Asserting rst_n mid-operation discards held contents at once.
- Update priority on each rising clk edge, with rst_n high:
  1. M_bubble=1: load NOP_OP/0/0/0/0 and M_valid=0. Bubble overrides stall.
  2. M_stall=1 (bubble=0): all outputs keep their values, M_valid included.
  3. Otherwise: M_op<=E_op, M_valE<=e_valE, M_valA<=E_valA, M_dstE<=E_dstE, M_dstM<=E_dstM, M_valid<=1.
- Latency:
  - Exactly one cycle.
  - Outputs are stable for the whole cycle after the edge.
  - Inputs changing between edges have no effect.
- Data handling:
  - Opcode and all fields pass through unmodified; no decode, no arithmetic, no sign extension.
  - Any opcode value is accepted (IROP 000000, IJ 000010, IADDI 001000, IANDI 001100, IORI 001101, ILW 100011, ISW 101011, others).
  - dstE/dstM equal to 0 mean "no write"; this is carried as-is.
- Unknown inputs: X on data inputs with plain capture is latched as X. Reset always clears X.

Test Plan:
1. Reset:
   - Drive rst_n=0 with inputs 0xFFFFFFFF/31/op 111111; toggle clk.
   - Required: outputs stay NOP_OP/0/0/0/0 with M_valid=0.
   - Release rst_n between edges; outputs unchanged until the next rising edge.
2. Sequential capture, inputs set before each rising edge:
   - (IROP,1), (IANDI,2), (IADDI,3), (IJ,4), (ILW,5), (ISW,6), (IORI,7), with valE=valA=dstE=dstM=n.
   - Required: after each edge M_op equals the applied opcode (000000, 001100, 001000, 000010, 100011, 101011, 001101), all other fields equal n, M_valid=1.
   - Input changes between edges do not alter outputs.
3. Stall:
   - Capture (ILW, valE=0x100, valA=0x55, dstE=0, dstM=8).
   - Assert M_stall for 2 edges while inputs change to (ISW,6,...).
   - Required: outputs still ILW/0x100/0x55/0/8; new values load on the first edge after stall drops.
4. Bubble and priority:
   - Assert M_bubble (and M_stall) at an edge with E_op=IADDI, valE=9.
   - Required: M_op=000000, all data 0, M_valid=0; next normal edge loads inputs.
5. Asynchronous reset mid-stream:
   - Pull rst_n low between clock edges while outputs hold (IORI,7).
   - Required: outputs clear immediately, without waiting for clk.
6. Full width:
   - Capture valE=0xFFFFFFFF, valA=0x80000000, dstE=31, dstM=31, op=111111.
   - Required: exact values appear, with no truncation or sign effects.
